bram_tdp_be_pipe: RTL and testbench

- Parametrised true dual-port block RAM on one clock; next generation of the team's dual-port BRAM primitive.
- Adds byte-write enables, independent per-port enables, a per-port write mode (NO_CHANGE / READ_FIRST / WRITE_FIRST) and a configurable read latency with valid tags.
- Adds deterministic write-write collision resolution with a collision flag.
- Used as the coefficient and LUT store for the non-linear approximation engines.

---
 rtl/bram_pkg.sv | 29 ++
 rtl/bram_rd_pipe.sv | 42 ++++
 rtl/bram_tdp_be_pipe.sv | 123 ++++++++++++
 tb/tb_bram_tdp_be_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enabled dual-port BRAM: write modes,
// legal read latencies and the byte-lane merge helper.
package bram_pkg;

  localparam int NO_CHANGE   = 0;
  localparam int READ_FIRST  = 1;
  localparam int WRITE_FIRST = 2;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;

  // The merge helper works on a fixed maximum width; callers zero-extend and truncate.
  localparam int MERGE_WIDTH_MAX = 256;
  localparam int MERGE_BYTES_MAX = MERGE_WIDTH_MAX / 8;

  function automatic logic [MERGE_WIDTH_MAX-1:0] merge_bytes(
    input logic [MERGE_WIDTH_MAX-1:0] old_word,
    input logic [MERGE_WIDTH_MAX-1:0] new_word,
    input logic [MERGE_BYTES_MAX-1:0] we
  );
    logic [MERGE_WIDTH_MAX-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BYTES_MAX; i++) begin
      if (we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data pipeline stages 2..READ_LAT for one BRAM port; stages always
// advance, so dout keeps its last value while valid bubbles are flowing.
module bram_rd_pipe #(
  parameter int RAM_WIDTH = 32,
  parameter int READ_LAT  = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [RAM_WIDTH-1:0] stage1_data,
  input  logic                 stage1_valid,
  output logic [RAM_WIDTH-1:0] dout,
  output logic                 valid
);

  if (READ_LAT <= 1) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rstn_i;
    assign dout  = stage1_data;
    assign valid = stage1_valid;
  end else begin : g_regs
    logic [READ_LAT-2:0][RAM_WIDTH-1:0] data_q;
    logic [READ_LAT-2:0]                valid_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q[0]  <= stage1_data;
        valid_q[0] <= stage1_valid;
        for (int i = 1; i < READ_LAT - 1; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign dout  = data_q[READ_LAT-2];
    assign valid = valid_q[READ_LAT-2];
  end

endmodule

// File: rtl/bram_tdp_be_pipe.sv
// True dual-port block RAM with byte enables, per-port write modes,
// configurable read latency with valid tags and write-write collision flag.
module bram_tdp_be_pipe
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_LINES,
  parameter int READ_LAT   = 2,
  parameter int MODE_A     = NO_CHANGE,
  parameter int MODE_B     = NO_CHANGE
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   ena,
  input  logic [RAM_WIDTH/8-1:0] wea,
  input  logic [ADDR_LINES-1:0]  addra,
  input  logic [RAM_WIDTH-1:0]   dina,
  output logic [RAM_WIDTH-1:0]   douta,
  output logic                   valida,
  input  logic                   enb,
  input  logic [RAM_WIDTH/8-1:0] web,
  input  logic [ADDR_LINES-1:0]  addrb,
  input  logic [RAM_WIDTH-1:0]   dinb,
  output logic [RAM_WIDTH-1:0]   doutb,
  output logic                   validb,
  output logic                   collision
);

  localparam int NBYTES = RAM_WIDTH / 8;

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("bram_tdp_be_pipe: READ_LAT must be within 1..3");
  end
  if (RAM_WIDTH % 8 != 0) begin : g_bad_width
    $error("bram_tdp_be_pipe: RAM_WIDTH must be a multiple of 8");
  end
  if (RAM_WIDTH > MERGE_WIDTH_MAX) begin : g_too_wide
    $error("bram_tdp_be_pipe: RAM_WIDTH exceeds merge helper width");
  end

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // Port A is assigned last so it wins every lane both ports write.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (enb && web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
      if (ena && wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam int MODE = (gi == 0) ? MODE_A : MODE_B;

    logic                  port_en;
    logic [NBYTES-1:0]     port_we;
    logic [ADDR_LINES-1:0] port_addr;
    logic [RAM_WIDTH-1:0]  port_din;
    logic [RAM_WIDTH-1:0]  old_word;
    logic [RAM_WIDTH-1:0]  new_word;
    logic [RAM_WIDTH-1:0]  s1_data_reg;
    logic                  s1_valid_reg;
    logic [RAM_WIDTH-1:0]  pipe_dout;
    logic                  pipe_valid;

    assign port_en   = (gi == 0) ? ena   : enb;
    assign port_we   = (gi == 0) ? wea   : web;
    assign port_addr = (gi == 0) ? addra : addrb;
    assign port_din  = (gi == 0) ? dina  : dinb;

    // Array is read before this edge's writes land: read-first across ports.
    assign old_word = mem[port_addr];
    assign new_word = RAM_WIDTH'(merge_bytes(MERGE_WIDTH_MAX'(old_word),
                                             MERGE_WIDTH_MAX'(port_din),
                                             MERGE_BYTES_MAX'(port_we)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        s1_data_reg  <= '0;
        s1_valid_reg <= 1'b0;
      end else if (!port_en) begin
        s1_valid_reg <= 1'b0;
      end else if (port_we == '0) begin
        s1_data_reg  <= old_word;
        s1_valid_reg <= 1'b1;
      end else if (MODE == READ_FIRST) begin
        s1_data_reg  <= old_word;
        s1_valid_reg <= 1'b1;
      end else if (MODE == WRITE_FIRST) begin
        s1_data_reg  <= new_word;
        s1_valid_reg <= 1'b1;
      end else begin
        s1_valid_reg <= 1'b0;
      end
    end

    bram_rd_pipe #(
      .RAM_WIDTH (RAM_WIDTH),
      .READ_LAT  (READ_LAT)
    ) u_rd_pipe (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .stage1_data  (s1_data_reg),
      .stage1_valid (s1_valid_reg),
      .dout         (pipe_dout),
      .valid        (pipe_valid)
    );
  end

  assign douta  = g_port[0].pipe_dout;
  assign valida = g_port[0].pipe_valid;
  assign doutb  = g_port[1].pipe_dout;
  assign validb = g_port[1].pipe_valid;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      collision <= 1'b0;
    end else begin
      collision <= ena && enb && (addra == addrb) && ((wea & web) != '0);
    end
  end

endmodule

// File: tb/tb_bram_tdp_be_pipe.sv
// Directed bench: three instances (READ_LAT 1/2/3, mixed write modes) share
// one stimulus stream and are checked against hand-computed values.
module tb_bram_tdp_be_pipe;
  import bram_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [3:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta [3];
  logic [31:0] doutb [3];
  logic        valida [3];
  logic        validb [3];
  logic        collision [3];

  logic [31:0] model [16];
  logic        en_hist [32];
  logic [3:0]  addr_hist [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  bram_tdp_be_pipe #(.READ_LAT(1), .MODE_A(READ_FIRST), .MODE_B(WRITE_FIRST)) u_lat1 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[0]), .valida(valida[0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[0]), .validb(validb[0]),
    .collision(collision[0]));

  bram_tdp_be_pipe #(.READ_LAT(2), .MODE_A(NO_CHANGE), .MODE_B(NO_CHANGE)) u_lat2 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[1]), .valida(valida[1]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[1]), .validb(validb[1]),
    .collision(collision[1]));

  bram_tdp_be_pipe #(.READ_LAT(3), .MODE_A(WRITE_FIRST), .MODE_B(READ_FIRST)) u_lat3 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[2]), .valida(valida[2]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[2]), .validb(validb[2]),
    .collision(collision[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic write_a(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    ena = 1'b1; wea = be; addra = addr; dina = data;
    tick(); idle();
    $display("write A addr=%0d data=%h be=%b", addr, data, be);
  endtask

  task automatic write_b(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    enb = 1'b1; web = be; addrb = addr; dinb = data;
    tick(); idle();
    $display("write B addr=%0d data=%h be=%b", addr, data, be);
  endtask

  // Issue one B read (plus whatever A is already driving) and check each
  // instance at its own latency.
  task automatic read_b(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    enb = 1'b1; web = '0; addrb = addr;
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      check($sformatf("%s_v_lat%0d", tag, k + 1), 32'(validb[k]), 32'd1);
      check($sformatf("%s_d_lat%0d", tag, k + 1), doutb[k], exp);
    end
    $display("read B %s addr=%0d expect=%h", tag, addr, exp);
  endtask

  task automatic read_a(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    ena = 1'b1; wea = '0; addra = addr;
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      check($sformatf("%s_v_lat%0d", tag, k + 1), 32'(valida[k]), 32'd1);
      check($sformatf("%s_d_lat%0d", tag, k + 1), douta[k], exp);
    end
    $display("read A %s addr=%0d expect=%h", tag, addr, exp);
  endtask

  initial begin
    int a;
    int idx;
    rstn_i = 1'b0;
    idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_douta_%0d", k), douta[k], 32'h0);
      check($sformatf("rst_doutb_%0d", k), doutb[k], 32'h0);
      check($sformatf("rst_valida_%0d", k), 32'(valida[k]), 32'h0);
      check($sformatf("rst_validb_%0d", k), 32'(validb[k]), 32'h0);
      check($sformatf("rst_coll_%0d", k), 32'(collision[k]), 32'h0);
    end
    $display("reset state checked");
    rstn_i = 1'b1;
    tick();

    // Reset while reads are still in flight.
    write_a(4'd4, 32'h1234_5678, 4'hF);
    ena = 1'b1; wea = '0; addra = 4'd4;
    tick(); idle();
    check("midrd_lat1_d", douta[0], 32'h1234_5678);
    rstn_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_d_lat%0d", k + 1), douta[k], 32'h0);
      check($sformatf("midrst_v_lat%0d", k + 1), 32'(valida[k]), 32'h0);
    end
    #1 rstn_i = 1'b1;
    tick(); tick(); tick();
    check("postrst_v_lat3", 32'(valida[2]), 32'h0);
    check("postrst_d_lat3", douta[2], 32'h0);
    $display("reset mid-read checked");

    // Exact read latency per instance.
    write_a(4'd3, 32'hDEAD_BEEF, 4'hF);
    enb = 1'b1; web = '0; addrb = 4'd3;
    tick(); idle();
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("lat_v_c%0d_lat%0d", c, k + 1), 32'(validb[k]), 32'((k + 1) == c));
        if ((k + 1) == c) check($sformatf("lat_d_lat%0d", k + 1), doutb[k], 32'hDEAD_BEEF);
      end
    end
    $display("latency check done");

    // Byte enables.
    write_a(4'd5, 32'h1122_3344, 4'hF);
    write_a(4'd5, 32'hAABB_CCDD, 4'b0101);
    read_b(4'd5, 32'h11BB_33DD, "be");

    // Port A write modes: lat1=READ_FIRST, lat2=NO_CHANGE, lat3=WRITE_FIRST.
    write_b(4'd7, 32'h0, 4'hF);
    read_a(4'd5, 32'h11BB_33DD, "wm_pre");
    ena = 1'b1; wea = 4'hF; addra = 4'd7; dina = 32'h5;
    tick(); idle();
    check("rf_v", 32'(valida[0]), 32'd1);
    check("rf_d", douta[0], 32'h0);
    tick();
    check("nc_v", 32'(valida[1]), 32'd0);
    check("nc_d", douta[1], 32'h11BB_33DD);
    tick();
    check("wf_v", 32'(valida[2]), 32'd1);
    check("wf_d", douta[2], 32'h5);
    $display("write modes checked");
    read_a(4'd7, 32'h5, "wm_rd");

    // Same-address write collision with overlapping lanes.
    write_a(4'd2, 32'h0, 4'hF);
    ena = 1'b1; wea = 4'b0011; addra = 4'd2; dina = 32'hAAAA_AAAA;
    enb = 1'b1; web = 4'b0110; addrb = 4'd2; dinb = 32'hBBBB_BBBB;
    tick(); idle();
    for (int k = 0; k < 3; k++) check($sformatf("coll_hi_%0d", k), 32'(collision[k]), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) check($sformatf("coll_clr_%0d", k), 32'(collision[k]), 32'd0);
    read_b(4'd2, 32'h00BB_AAAA, "coll_mem");

    // Disjoint lanes, then different addresses: no collision.
    ena = 1'b1; wea = 4'b0001; addra = 4'd2; dina = 32'h1111_1111;
    enb = 1'b1; web = 4'b1000; addrb = 4'd2; dinb = 32'h2222_2222;
    tick(); idle();
    for (int k = 0; k < 3; k++) check($sformatf("disj_coll_%0d", k), 32'(collision[k]), 32'd0);
    read_b(4'd2, 32'h22BB_AA11, "disj_mem");
    ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'h3333_3333;
    enb = 1'b1; web = 4'hF; addrb = 4'd6; dinb = 32'h4444_4444;
    tick(); idle();
    check("diffaddr_coll", 32'(collision[1]), 32'd0);
    $display("collision checks done");

    // Cross-port: B reads while A writes the same address.
    write_a(4'd9, 32'h1, 4'hF);
    ena = 1'b1; wea = 4'hF; addra = 4'd9; dina = 32'h2;
    read_b(4'd9, 32'h1, "xp_old");
    read_b(4'd9, 32'h2, "xp_new");

    // Streaming reads with a bubble every 4th cycle.
    for (int i = 0; i < 16; i++) begin
      model[i] = 32'hA000_0000 + 32'(i) * 32'h0000_0101;
      write_a(4'(i), model[i], 4'hF);
    end
    a = 0;
    for (int c = 0; c < 24; c++) begin
      if (a < 16 && (c % 4) != 3) begin
        enb = 1'b1; addrb = 4'(a);
        en_hist[c] = 1'b1; addr_hist[c] = 4'(a);
        a++;
      end else begin
        enb = 1'b0;
        en_hist[c] = 1'b0; addr_hist[c] = '0;
      end
      web = '0;
      tick();
      for (int k = 0; k < 3; k++) begin
        idx = c - k;
        if (idx >= 0) begin
          check($sformatf("strm_v_c%0d_lat%0d", c, k + 1), 32'(validb[k]), 32'(en_hist[idx]));
          if (en_hist[idx])
            check($sformatf("strm_d_c%0d_lat%0d", c, k + 1), doutb[k], model[addr_hist[idx]]);
        end
      end
      $display("stream cycle %0d enb=%0d addr=%0d", c, en_hist[c], addr_hist[c]);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
